// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer slice.
package reset_seq_pkg;

  // Sequencer phases: hold everything, release one domain at a time, steady, or timed out.
  typedef enum logic [1:0] {HOLD, WAIT_ACK, RUN, FAULT} rs_state_t;

  // Widest domain vector the sequencer is meant to drive.
  localparam int MAX_DOMAINS = 8;

  // Width of a domain index. It is never narrower than one bit, so a single-domain
  // build still has a usable fault_domain port.
  function automatic int fd_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Domain-side bundle: restart request and per-domain acks in; resets and status out.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3
);
  localparam int FD_W = fd_width(NUM_DOMAINS);

  logic                   sw_reset_req;
  logic [NUM_DOMAINS-1:0] domain_ack;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic                   all_ready;
  logic                   busy;
  logic                   fault;
  logic [FD_W-1:0]        fault_domain;

  // The sequencer side drives resets and status.
  modport master (
    input  sw_reset_req, domain_ack,
    output domain_reset, all_ready, busy, fault, fault_domain
  );

  // The board/domain side consumes resets and returns acknowledges.
  modport slave (
    output sw_reset_req, domain_ack,
    input  domain_reset, all_ready, busy, fault, fault_domain
  );
endinterface

// File: rtl/reset_sequencer_cycle_timer.sv
// Saturating cycle counter with an exact-match terminal flag.
// done is high during the enabled cycle whose edge would make count reach TARGET,
// so the owner can act on that same edge. TARGET=0 never fires.
module cycle_timer #(
  parameter int CNT_W  = 16,
  parameter int TARGET = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TGT     = (CNT_W + 1)'(TARGET);

  logic [CNT_W-1:0] count_reg;

  // The compare uses one extra bit, so a saturated counter can never alias onto TARGET.
  assign done = enable && (({1'b0, count_reg} + (CNT_W + 1)'(1)) == TGT);

  // The count clears on reset or request, advances when enabled, and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// Power-on / on-demand reset sequencer.
// It holds all domains in reset, then releases them in index order.
// Each release waits for the previous domain's ack.
// An ack that does not arrive in time raises a sticky fault.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 20,
  parameter int ACK_TIMEOUT = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  reset_sequencer_if.master   sif
);
  localparam int              FD_W     = fd_width(NUM_DOMAINS);
  localparam logic [FD_W-1:0] LAST_IDX = FD_W'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > MAX_DOMAINS || HOLD_CYCLES < 1) begin : g_bad_params
    $error("reset_sequencer: NUM_DOMAINS must be 1..8 and HOLD_CYCLES >= 1");
  end

  rs_state_t              state_reg;
  logic [NUM_DOMAINS-1:0] dr_reg;
  logic                   all_ready_reg;
  logic                   busy_reg;
  logic                   fault_reg;
  logic [FD_W-1:0]        fault_domain_reg;
  logic [FD_W-1:0]        idx_reg;

  logic [NUM_DOMAINS-1:0] ack_sel;
  logic                   ack_cur;
  logic                   hold_done;
  logic                   ack_timeout;

  // Select the ack of the domain being waited on.
  // This is a one-hot AND-OR, so a non-power-of-two domain count never indexes past the vector.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_ack_sel
    assign ack_sel[gi] = sif.domain_ack[gi] && (idx_reg == FD_W'(gi));
  end
  assign ack_cur = |ack_sel;

  // The hold timer runs only in HOLD while no software request is pending.
  // A pending request keeps it pinned at zero, so the hold count starts when the request falls.
  cycle_timer #(
    .CNT_W  (CNT_W),
    .TARGET (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (sif.sw_reset_req || (state_reg != HOLD)),
    .enable (state_reg == HOLD),
    .done   (hold_done)
  );

  // The ack timer counts consecutive cycles with no ack for the current domain.
  // Each release or ack restarts it.
  cycle_timer #(
    .CNT_W  (CNT_W),
    .TARGET (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (sif.sw_reset_req || (state_reg != WAIT_ACK) || ack_cur),
    .enable ((state_reg == WAIT_ACK) && !ack_cur),
    .done   (ack_timeout)
  );

  // Sequencer FSM. Every output is a register updated here. A restart request overrides everything else.
  always_ff @(posedge clk) begin
    if (reset || sif.sw_reset_req) begin
      state_reg        <= HOLD;
      dr_reg           <= '1;
      all_ready_reg    <= 1'b0;
      busy_reg         <= 1'b1;
      fault_reg        <= 1'b0;
      fault_domain_reg <= '0;
      idx_reg          <= '0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (hold_done) begin
            state_reg <= WAIT_ACK;
            dr_reg[0] <= 1'b0;
            idx_reg   <= '0;
          end
        end
        WAIT_ACK: begin
          if (ack_cur) begin
            if (idx_reg == LAST_IDX) begin
              state_reg     <= RUN;
              all_ready_reg <= 1'b1;
              busy_reg      <= 1'b0;
            end else begin
              dr_reg  <= dr_reg & ~(NUM_DOMAINS'(1) << (idx_reg + 1'b1));
              idx_reg <= idx_reg + 1'b1;
            end
          end else if (ack_timeout) begin
            state_reg        <= FAULT;
            dr_reg           <= '1;
            fault_reg        <= 1'b1;
            fault_domain_reg <= idx_reg;
            busy_reg         <= 1'b0;
            all_ready_reg    <= 1'b0;
          end
        end
        RUN:     state_reg <= RUN;
        FAULT:   state_reg <= FAULT;
        default: state_reg <= HOLD;
      endcase
    end
  end

  assign sif.domain_reset = dr_reg;
  assign sif.all_ready    = all_ready_reg;
  assign sif.busy         = busy_reg;
  assign sif.fault        = fault_reg;
  assign sif.fault_domain = fault_domain_reg;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// Stimulus comes from a table of vectors, hand-written corner sequences and a random run.
// A count-based reference model predicts every cycle.
module tb_reset_sequencer;
  localparam int N      = 3;
  localparam int P_HOLD = 20;
  localparam int P_TO   = 10;
  localparam int P_CW   = 16;
  localparam int FDW    = reset_seq_pkg::fd_width(N);
  localparam int OW     = N + 3 + FDW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_DOMAINS(N)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS (N),
    .HOLD_CYCLES (P_HOLD),
    .ACK_TIMEOUT (P_TO),
    .CNT_W       (P_CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, kept as counts rather than FSM states:
  // m_rel = number of domains released so far, m_hold/m_wait = edges counted in each phase.
  int m_rel, m_hold, m_wait, m_ready, m_fault, m_fdom;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge, using the inputs that edge sampled.
  task automatic model_edge(input bit r, input bit s, input logic [N-1:0] a);
    if (r || s) begin
      m_rel = 0; m_hold = 0; m_wait = 0; m_ready = 0; m_fault = 0; m_fdom = 0;
    end else if (m_ready != 0 || m_fault != 0) begin
      // steady: RUN or FAULT
    end else if (m_rel == 0) begin
      m_hold++;
      if (m_hold == P_HOLD) begin
        m_rel = 1; m_wait = 0;
      end
    end else if (a[m_rel-1]) begin
      if (m_rel == N) m_ready = 1;
      else begin m_rel++; m_wait = 0; end
    end else begin
      m_wait++;
      if (P_TO > 0 && m_wait == P_TO) begin
        m_fault = 1; m_fdom = m_rel - 1; m_rel = 0;
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [N-1:0] dr;
    dr = {N{1'b1}} << m_rel;
    return {dr, m_ready[0], (m_ready == 0 && m_fault == 0), m_fault[0], FDW'(m_fdom)};
  endfunction

  // One transaction: drive inputs, take one edge, then compare every output with the model.
  task automatic step(input bit r, input bit s, input logic [N-1:0] a, input string tag);
    logic [OW-1:0] act;
    logic [OW-1:0] exp;
    reset = r; bus.sw_reset_req = s; bus.domain_ack = a;
    @(posedge clk); #1;
    model_edge(r, s, a);
    act = {bus.domain_reset, bus.all_ready, bus.busy, bus.fault, bus.fault_domain};
    exp = model_out();
    $display("%0t %s r=%0b sw=%0b ack=%b -> dr=%b rdy=%0b busy=%0b flt=%0b fd=%0d",
             $time, tag, r, s, a, bus.domain_reset, bus.all_ready, bus.busy, bus.fault, bus.fault_domain);
    chk({tag, "/model"}, 32'(act), 32'(exp));
  endtask

  task automatic run(input int n, input logic [N-1:0] a, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, tag);
  endtask

  typedef struct {
    int           edges;
    logic [N-1:0] ack;
    logic [N-1:0] dr;
    bit           ready;
    bit           busy;
  } vec_t;

  vec_t         tbl [6];
  logic [N-1:0] stuck;
  logic [N-1:0] ra;

  initial begin
    // Power-on release with all acks tied high. Each row gives the edges to advance, then the state expected.
    tbl[0] = '{19, 3'b111, 3'b111, 1'b0, 1'b1};
    tbl[1] = '{1,  3'b111, 3'b110, 1'b0, 1'b1};
    tbl[2] = '{1,  3'b111, 3'b100, 1'b0, 1'b1};
    tbl[3] = '{1,  3'b111, 3'b000, 1'b0, 1'b1};
    tbl[4] = '{1,  3'b111, 3'b000, 1'b1, 1'b0};
    tbl[5] = '{10, 3'b000, 3'b000, 1'b1, 1'b0};

    // Reset state
    step(1'b1, 1'b0, 3'b111, "rst");
    step(1'b1, 1'b0, 3'b111, "rst");
    chk("rst_dr", 32'(bus.domain_reset), 32'h7);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_ready", 32'(bus.all_ready), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);

    // Test 1: table-driven power-on sequence (the last row checks that RUN ignores dropped acks)
    for (int v = 0; v < 6; v++) begin
      run(tbl[v].edges, tbl[v].ack, "t1");
      chk($sformatf("t1_dr_%0d", v), 32'(bus.domain_reset), 32'(tbl[v].dr));
      chk($sformatf("t1_ready_%0d", v), 32'(bus.all_ready), 32'(tbl[v].ready));
      chk($sformatf("t1_busy_%0d", v), 32'(bus.busy), 32'(tbl[v].busy));
    end

    // Test 2: ack[1] arrives 7 cycles after dr[1] falls; dr[2] follows one edge later
    step(1'b0, 1'b1, 3'b101, "t2");
    run(21, 3'b101, "t2");
    chk("t2_dr1_fell", 32'(bus.domain_reset), 32'h4);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 3'b101, "t2");
      chk("t2_wait_dr", 32'(bus.domain_reset), 32'h4);
      chk("t2_wait_busy", 32'(bus.busy), 32'h1);
    end
    step(1'b0, 1'b0, 3'b111, "t2");
    chk("t2_dr2_fell", 32'(bus.domain_reset), 32'h0);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    step(1'b0, 1'b0, 3'b111, "t2");
    chk("t2_ready", 32'(bus.all_ready), 32'h1);

    // Test 3: ack[2] never arrives, so the timeout fires after exactly 10 waiting edges
    step(1'b0, 1'b1, 3'b011, "t3");
    run(22, 3'b011, "t3");
    run(9, 3'b011, "t3");
    chk("t3_prefault", 32'(bus.fault), 32'h0);
    step(1'b0, 1'b0, 3'b011, "t3");
    chk("t3_fault", 32'(bus.fault), 32'h1);
    chk("t3_fdom", 32'(bus.fault_domain), 32'h2);
    chk("t3_dr", 32'(bus.domain_reset), 32'h7);
    chk("t3_busy", 32'(bus.busy), 32'h0);
    run(100, 3'b111, "t3");
    chk("t3_hold_fault", 32'(bus.fault), 32'h1);
    chk("t3_hold_dr", 32'(bus.domain_reset), 32'h7);

    // Test 4: a software pulse clears the fault and the full sequence runs again
    step(1'b0, 1'b1, 3'b111, "t4");
    chk("t4_fault_clr", 32'(bus.fault), 32'h0);
    chk("t4_dr", 32'(bus.domain_reset), 32'h7);
    chk("t4_busy", 32'(bus.busy), 32'h1);
    run(23, 3'b111, "t4");
    chk("t4_ready", 32'(bus.all_ready), 32'h1);

    // Test 5: block reset while waiting on ack[1]
    step(1'b0, 1'b1, 3'b001, "t5");
    run(22, 3'b001, "t5");
    chk("t5_waiting", 32'(bus.domain_reset), 32'h4);
    step(1'b1, 1'b0, 3'b001, "t5");
    chk("t5_dr", 32'(bus.domain_reset), 32'h7);
    chk("t5_busy", 32'(bus.busy), 32'h1);
    run(20, 3'b111, "t5");
    chk("t5_dr0_first", 32'(bus.domain_reset), 32'h6);
    run(3, 3'b111, "t5");
    chk("t5_ready", 32'(bus.all_ready), 32'h1);
    chk("t5_fault", 32'(bus.fault), 32'h0);

    // Test 6: a software request on the same edge as the final ack wins
    step(1'b0, 1'b1, 3'b111, "t6");
    run(22, 3'b111, "t6");
    step(1'b0, 1'b1, 3'b111, "t6");
    chk("t6_ready", 32'(bus.all_ready), 32'h0);
    chk("t6_dr", 32'(bus.domain_reset), 32'h7);
    run(23, 3'b111, "t6");
    chk("t6_ready_end", 32'(bus.all_ready), 32'h1);

    // Random run. In each segment, a random mask holds some acks low so that timeouts occur.
    stuck = '0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) stuck = N'($urandom_range(0, 7));
      for (int b = 0; b < N; b++) ra[b] = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0), ra & ~stuck, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
